// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART transmit scheduler.
//   byte_t        : one UART payload byte
//   sched_state_t : scheduler FSM states (IDLE, SEND, GAP)
//   rr_next       : advance a round-robin pointer, wrapping at n
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } sched_state_t;

    // Next pointer after a grant to 'ptr' among 'n' sources.
    function automatic int rr_next(input int ptr, input int n);
        if (ptr + 1 >= n) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word fall-through read data.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the push is ignored (the caller decides what that means).
// Ports:
//   clk   in   clock
//   rstn  in   synchronous active-low reset (empties the FIFO)
//   push  in   write din this cycle
//   pop   in   consume dout this cycle (ignored when empty)
//   din   in   WIDTH write data
//   dout  out  WIDTH oldest entry (valid when !empty)
//   full  out  DEPTH entries stored
//   empty out  no entries stored
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A full FIFO can still take a byte when one leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Shares one UART sender between the receiver echo path (source 0, buffered
// in a FIFO because the receiver cannot be stalled) and N_REQ handshaked
// requesters (sources 1..N_REQ). Sources are served round-robin, one byte at
// a time, with an IDLE -> SEND -> GAP cycle per byte.
// Ports:
//   CLK          in   system clock
//   RSTN         in   synchronous active-low reset
//   rx_data      in   8        byte from receiver
//   rx_valid     in   1        one-cycle pulse, rx_data valid
//   req_data     in   8*N_REQ  requester i byte in bits [8i+7:8i]
//   req_valid    in   N_REQ    requester i has a byte
//   req_ready    out  N_REQ    requester i byte taken this cycle (pulse)
//   tx_data      out  8        byte offered to sender
//   tx_enable    out  1        byte offered to sender
//   tx_ready     in   1        sender idle/accepting
//   rx_overflow  out  1        sticky, an echo byte was dropped
//   busy         out  1        FSM not IDLE or echo FIFO non-empty
// ---------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_enable,
    input  logic               tx_ready,
    output logic               rx_overflow,
    output logic               busy
);

    localparam int N_SRC = N_REQ + 1;
    localparam int SRC_W = $clog2(N_SRC);

    sched_state_t     state;
    sched_state_t     state_next;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] winner;
    logic [N_SRC-1:0] src_req;
    logic             any_req;
    logic             grant;
    byte_t            win_byte;
    byte_t            tx_data_next;
    logic             tx_enable_next;
    byte_t            fifo_dout;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    // First requesting source at or after 'start', wrapping over N_SRC.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                                 input logic [SRC_W-1:0] start);
        logic [SRC_W-1:0] sel;
        logic [SRC_W-1:0] idx;
        logic             found;
        int               pos;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            pos = int'(start) + i;
            if (pos >= N_SRC) begin
                pos = pos - N_SRC;
            end
            idx = SRC_W'(pos);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_echo_fifo (
        .clk   (CLK),
        .rstn  (RSTN),
        .push  (rx_valid),
        .pop   (fifo_pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign src_req = {req_valid, !fifo_empty};
    assign any_req = |src_req;
    assign winner  = rr_pick(src_req, rr_ptr);
    assign busy    = (state != IDLE) || !fifo_empty;

    // Byte of the current round-robin winner.
    always_comb begin
        win_byte = fifo_dout;
        for (int k = 0; k < N_REQ; k++) begin
            if (int'(winner) == k + 1) begin
                win_byte = req_data[8*k +: 8];
            end
        end
    end

    // Next-state and next-output logic. Grants only in IDLE while the sender
    // is ready, and never while reset is applied, so req_ready and the FIFO
    // pop stay quiet during reset.
    always_comb begin
        state_next     = state;
        tx_enable_next = tx_enable;
        tx_data_next   = tx_data;
        grant          = 1'b0;
        case (state)
            IDLE: begin
                if (RSTN && tx_ready && any_req) begin
                    grant          = 1'b1;
                    tx_data_next   = win_byte;
                    tx_enable_next = 1'b1;
                    state_next     = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_enable_next = 1'b0;
                    state_next     = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next     = IDLE;
                tx_enable_next = 1'b0;
            end
        endcase
    end

    // Grant fan-out: one-cycle ready pulse to a requester, or a FIFO pop.
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready[k] = grant && (int'(winner) == k + 1);
        end
    end

    assign fifo_pop = grant && (winner == '0);

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output registers, round-robin pointer and sticky overflow flag.
    // An echo byte is lost only when the FIFO is full and nothing leaves it.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            tx_enable   <= 1'b0;
            tx_data     <= '0;
            rr_ptr      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            tx_enable <= tx_enable_next;
            tx_data   <= tx_data_next;
            if (grant) begin
                rr_ptr <= SRC_W'(rr_next(int'(winner), N_SRC));
            end
            if (rx_valid && fifo_full && !fifo_pop) begin
                rx_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched (N_REQ=2, FIFO_DEPTH=16).
// A behavioural sender drops tx_ready for frame_len cycles after each
// transfer. Expected sender bytes are queued as stimulus is driven and
// compared when a transfer is seen.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int N_REQ = 2;

    logic               CLK;
    logic               RSTN;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_enable;
    logic               tx_ready;
    logic               rx_overflow;
    logic               busy;

    int         vectors     = 0;
    int         miscompares = 0;
    int         transfers   = 0;
    int         frame_len   = 100;
    int         frame_left  = 0;
    logic       sender_on   = 1'b1;
    logic       hold_low    = 1'b0;
    logic [7:0] exp_q [$];
    int         pulse_cnt [N_REQ];

    typedef struct {
        logic       rstn;
        logic       rxv;
        logic [7:0] rxd;
        logic       en;
        logic [7:0] data;
        logic       busy;
        logic       ovf;
    } vec_t;

    vec_t tbl [7];

    uart_tx_sched #(
        .N_REQ      (N_REQ),
        .FIFO_DEPTH (16)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_ready    (tx_ready),
        .rx_overflow (rx_overflow),
        .busy        (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Sender model: a transfer (tx_enable && tx_ready at an edge) starts a
    // frame during which tx_ready stays low.
    initial begin
        logic xfer;
        tx_ready = 1'b0;
        forever begin
            @(negedge CLK);
            xfer = RSTN && tx_enable && tx_ready;
            @(posedge CLK);
            #2;
            if (xfer) begin
                frame_left = frame_len;
            end else if (frame_left > 0) begin
                frame_left--;
            end
            tx_ready = sender_on && !hold_low && (frame_left == 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        RSTN     = v.rstn;
        rx_valid = v.rxv;
        rx_data  = v.rxd;
        if (v.rxv && v.rstn) begin
            exp_q.push_back(v.rxd);
        end
    endtask

    // One clock: sample at negedge (transfers, req_ready), then return 1
    // time unit after the next rising edge with rx_valid cleared and any
    // acknowledged requester dropped.
    task automatic step();
        logic [N_REQ-1:0] acked;
        logic [7:0]       want;
        @(negedge CLK);
        if (RSTN && tx_enable && tx_ready) begin
            transfers++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL tx_unexpected: got %0h, want no transfer", tx_data);
            end else begin
                want = exp_q.pop_front();
                checkOutput("tx_byte", tx_data, want);
            end
        end
        acked = req_ready;
        if (acked != '0) begin
            checkOutput("req_ready_onehot",
                        ($countones(acked) == 1) && ((acked & ~req_valid) == '0), 1);
            for (int k = 0; k < N_REQ; k++) begin
                if (acked[k]) pulse_cnt[k]++;
            end
        end
        @(posedge CLK);
        #1;
        req_valid = req_valid & ~acked;
        rx_valid  = 1'b0;
    endtask

    task automatic doReset();
        RSTN      = 1'b0;
        req_valid = '0;
        rx_valid  = 1'b0;
        step();
        step();
        RSTN = 1'b1;
        exp_q.delete();
        for (int k = 0; k < N_REQ; k++) pulse_cnt[k] = 0;
    endtask

    task automatic waitDrain(input string name, input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
            step();
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic checkRow(input int i);
        checkOutput($sformatf("row%0d_tx_enable", i), tx_enable, tbl[i].en);
        checkOutput($sformatf("row%0d_tx_data", i), tx_data, tbl[i].data);
        checkOutput($sformatf("row%0d_busy", i), busy, tbl[i].busy);
        checkOutput($sformatf("row%0d_rx_overflow", i), rx_overflow, tbl[i].ovf);
    endtask

    initial begin
        int t0;
        int n;
        RSTN      = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        req_data  = '0;
        req_valid = '0;
        for (int k = 0; k < N_REQ; k++) pulse_cnt[k] = 0;

        //            rstn  rxv   rxd    en    data   busy  ovf
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 1'b0};

        $display("[TB] reset and idle");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(tbl[i]);
            step();
            checkRow(i);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            checkOutput($sformatf("idle%0d_tx_enable", c), tx_enable, 0);
        end

        $display("[TB] single echo");
        for (int i = 3; i < 7; i++) begin
            applyStimulus(tbl[i]);
            step();
            checkRow(i);
        end
        repeat (105) step();
        checkOutput("echo_transfers", transfers, 1);
        checkOutput("echo_busy", busy, 0);
        checkOutput("echo_queue", exp_q.size(), 0);

        $display("[TB] round-robin");
        frame_len = 4;
        sender_on = 1'b0;
        doReset();
        for (int r = 0; r < 2; r++) begin
            sender_on = 1'b0;
            for (int k = 0; k < N_REQ; k++) pulse_cnt[k] = 0;
            rx_valid  = 1'b1;
            rx_data   = 8'(8'h10 + r);
            req_data  = {8'(8'hB0 + r), 8'(8'hA0 + r)};
            req_valid = 2'b11;
            exp_q.push_back(8'(8'h10 + r));
            exp_q.push_back(8'(8'hA0 + r));
            exp_q.push_back(8'(8'hB0 + r));
            step();
            sender_on = 1'b1;
            waitDrain($sformatf("rr%0d_drain", r), 100);
            checkOutput($sformatf("rr%0d_pulses_req0", r), pulse_cnt[0], 1);
            checkOutput($sformatf("rr%0d_pulses_req1", r), pulse_cnt[1], 1);
        end

        $display("[TB] fifo overflow");
        sender_on = 1'b0;
        doReset();
        for (int i = 0; i < 17; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            if (i < 16) exp_q.push_back(8'(i));
            step();
            if (i == 15) checkOutput("ovf_after_16", rx_overflow, 0);
            if (i == 16) checkOutput("ovf_after_17", rx_overflow, 1);
        end
        t0 = transfers;
        sender_on = 1'b1;
        waitDrain("ovf_drain", 400);
        repeat (20) step();
        checkOutput("ovf_transfers", transfers - t0, 16);
        checkOutput("ovf_sticky", rx_overflow, 1);

        $display("[TB] full with simultaneous push and pop");
        sender_on = 1'b0;
        doReset();
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'h20 + i);
            exp_q.push_back(8'(8'h20 + i));
            step();
        end
        checkOutput("full_no_ovf", rx_overflow, 0);
        sender_on = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'h30;
        exp_q.push_back(8'h30);
        step();
        checkOutput("full_grant_en", tx_enable, 1);
        checkOutput("full_grant_data", tx_data, 8'h20);
        checkOutput("full_pushpop_ovf", rx_overflow, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        step();
        checkOutput("full_still_full_ovf", rx_overflow, 1);
        waitDrain("full_drain", 400);

        $display("[TB] reset mid-frame");
        sender_on = 1'b1;
        hold_low  = 1'b0;
        doReset();
        req_data[7:0] = 8'hC0;
        req_valid     = 2'b01;
        n = 0;
        while (pulse_cnt[0] == 0 && n < 10) begin
            step();
            n++;
        end
        checkOutput("mid_grant_pulse", pulse_cnt[0], 1);
        hold_low = 1'b1;
        checkOutput("mid_en_after_grant", tx_enable, 1);
        step();
        checkOutput("mid_en_held", tx_enable, 1);
        RSTN = 1'b0;
        step();
        checkOutput("mid_reset_en", tx_enable, 0);
        checkOutput("mid_reset_busy", busy, 0);
        checkOutput("mid_reset_data", tx_data, 0);
        RSTN = 1'b1;
        pulse_cnt[1]   = 0;
        req_data[15:8] = 8'hD0;
        req_valid      = 2'b10;
        exp_q.push_back(8'hD0);
        for (int c = 0; c < 6; c++) begin
            step();
            checkOutput($sformatf("mid_nogrant%0d_en", c), tx_enable, 0);
        end
        checkOutput("mid_nogrant_pulses", pulse_cnt[1], 0);
        hold_low = 1'b0;
        waitDrain("mid_drain", 60);
        checkOutput("mid_grant_req1", pulse_cnt[1], 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
